// File: rtl/sfm_pkg.sv
// Shared types for the softmax engine: command bit positions, datapath
// control/flag bundles, controller state encoding and stream request layout.
package sfm_pkg;

  // Bit positions inside the COMMANDS register
  localparam int CMD_ACC_ONLY = 0;
  localparam int CMD_DIV_ONLY = 1;
  localparam int CMD_PARTIAL  = 2;

  // Default widths of the streamer interface
  localparam int SFM_ADDR_W = 32;
  localparam int SFM_LEN_W  = 32;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLEAR    = 4'd1,
    ST_ACC_REQ  = 4'd2,
    ST_ACC_RUN  = 4'd3,
    ST_ACC_FIN  = 4'd4,
    ST_ACC_WAIT = 4'd5,
    ST_DIV_REQ  = 4'd6,
    ST_DIV_RUN  = 4'd7,
    ST_DIV_WAIT = 4'd8,
    ST_DONE     = 4'd9
  } ctrl_state_t;

  typedef struct packed {
    logic datapath_busy;
    logic reducing;
  } datapath_flags_t;

  typedef struct packed {
    logic acc_finished;
  } accumulator_ctrl_t;

  typedef struct packed {
    logic              clear_regs;
    accumulator_ctrl_t accumulator_ctrl;
    logic              dividing;
    logic              disable_max;
  } datapath_ctrl_t;

  // Stream request as seen by the streamer at the default widths
  typedef struct packed {
    logic [SFM_ADDR_W-1:0] rd_addr;
    logic [SFM_ADDR_W-1:0] wr_addr;
    logic [SFM_LEN_W-1:0]  len;
    logic                  write;
  } stream_req_t;

endpackage

// File: rtl/sfm_ctrl_fsm.sv
// Softmax job controller: latches the job registers on start, sequences the
// accumulate and divide passes through the streamer and reports completion.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for start; all outputs low
//  CLEAR    | one-cycle clear of the accumulator registers
//  ACC_REQ  | read request (accumulate pass) presented, held until ready
//  ACC_RUN  | read stream in flight, waiting for strm_done
//  ACC_FIN  | one-cycle acc_finished strobe to the accumulator
//  ACC_WAIT | waiting for the reduction/datapath to go idle
//  DIV_REQ  | write request (divide pass) presented, held until ready
//  DIV_RUN  | divide stream in flight, waiting for strm_done
//  DIV_WAIT | waiting for the datapath to drain the last results
//  DONE     | one-cycle done pulse
module sfm_ctrl_fsm
  import sfm_pkg::*;
#(
  parameter int ADDR_W = SFM_ADDR_W,
  parameter int LEN_W  = SFM_LEN_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [ADDR_W-1:0] out_addr_i,
  input  logic [LEN_W-1:0]  tot_len_i,
  input  logic [31:0]       commands_i,
  output logic              strm_valid_o,
  input  logic              strm_ready_i,
  output logic [ADDR_W-1:0] strm_rd_addr_o,
  output logic [ADDR_W-1:0] strm_wr_addr_o,
  output logic [LEN_W-1:0]  strm_len_o,
  output logic              strm_write_o,
  input  logic              strm_done_i,
  input  datapath_flags_t   dp_flags_i,
  output datapath_ctrl_t    dp_ctrl_o,
  output logic              busy_o,
  output logic              done_o
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_in_addr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [LEN_W-1:0]  r_tot_len;
  logic              r_acc_only;
  logic              r_div_only;
  logic              r_partial;

  logic w_start;
  logic w_in_acc;
  logic w_acc_partial;
  logic w_div;
  logic w_req_valid;
  logic w_dp_idle;
  logic w_unused_cmd;

  // Only the three mode bits of COMMANDS matter to this block
  assign w_unused_cmd = ^commands_i[31:3];

  assign w_start  = start_i && (r_state == ST_IDLE);
  // ACC_ONLY overrides DIV_ONLY when both are set
  assign w_in_acc = !commands_i[CMD_DIV_ONLY] || commands_i[CMD_ACC_ONLY];

  assign w_acc_partial = r_partial;
  assign w_div         = !r_acc_only;
  assign w_dp_idle     = !dp_flags_i.reducing && !dp_flags_i.datapath_busy;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Job fields are captured only on an accepted start; soft clear zeroes them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_addr  <= '0;
      r_out_addr <= '0;
      r_tot_len  <= '0;
      r_acc_only <= 1'b0;
      r_div_only <= 1'b0;
      r_partial  <= 1'b0;
    end else if (clear_i) begin
      r_in_addr  <= '0;
      r_out_addr <= '0;
      r_tot_len  <= '0;
      r_acc_only <= 1'b0;
      r_div_only <= 1'b0;
      r_partial  <= 1'b0;
    end else if (w_start) begin
      r_in_addr  <= in_addr_i;
      r_out_addr <= out_addr_i;
      r_tot_len  <= tot_len_i;
      r_acc_only <= commands_i[CMD_ACC_ONLY];
      r_div_only <= commands_i[CMD_DIV_ONLY];
      r_partial  <= commands_i[CMD_PARTIAL];
    end
  end

  // Next-state decode; soft clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (tot_len_i == '0)                            w_state_nxt = ST_DONE;
            else if (w_in_acc && !commands_i[CMD_PARTIAL])  w_state_nxt = ST_CLEAR;
            else if (w_in_acc)                              w_state_nxt = ST_ACC_REQ;
            else                                            w_state_nxt = ST_DIV_REQ;
          end
        end
        ST_CLEAR:    w_state_nxt = ST_ACC_REQ;
        ST_ACC_REQ:  if (strm_ready_i) w_state_nxt = ST_ACC_RUN;
        ST_ACC_RUN:  if (strm_done_i)  w_state_nxt = w_acc_partial ? ST_ACC_WAIT : ST_ACC_FIN;
        ST_ACC_FIN:  w_state_nxt = ST_ACC_WAIT;
        ST_ACC_WAIT: if (w_dp_idle)    w_state_nxt = w_div ? ST_DIV_REQ : ST_DONE;
        ST_DIV_REQ:  if (strm_ready_i) w_state_nxt = ST_DIV_RUN;
        ST_DIV_RUN:  if (strm_done_i)  w_state_nxt = ST_DIV_WAIT;
        ST_DIV_WAIT: if (!dp_flags_i.datapath_busy) w_state_nxt = ST_DONE;
        ST_DONE:     w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Moore outputs: decoded purely from the registered state
  always_comb begin
    w_req_valid   = 1'b0;
    strm_write_o  = 1'b0;
    dp_ctrl_o     = '0;
    done_o        = 1'b0;
    case (r_state)
      ST_CLEAR:    dp_ctrl_o.clear_regs = 1'b1;
      ST_ACC_REQ:  w_req_valid = 1'b1;
      ST_ACC_FIN:  dp_ctrl_o.accumulator_ctrl.acc_finished = 1'b1;
      ST_DIV_REQ: begin
        w_req_valid           = 1'b1;
        strm_write_o          = 1'b1;
        dp_ctrl_o.dividing    = 1'b1;
        dp_ctrl_o.disable_max = 1'b1;
      end
      ST_DIV_RUN, ST_DIV_WAIT: begin
        dp_ctrl_o.dividing    = 1'b1;
        dp_ctrl_o.disable_max = 1'b1;
      end
      ST_DONE:     done_o = 1'b1;
      default:     ;
    endcase
  end

  // Request fields are zero whenever no request is presented
  assign strm_valid_o   = w_req_valid;
  assign strm_rd_addr_o = w_req_valid ? r_in_addr  : '0;
  assign strm_wr_addr_o = w_req_valid ? r_out_addr : '0;
  assign strm_len_o     = w_req_valid ? r_tot_len  : '0;
  assign busy_o         = (r_state != ST_IDLE);

  // DIV_ONLY only matters through the start-cycle mode decode; kept for visibility
  logic w_unused_div_only;
  assign w_unused_div_only = r_div_only;

endmodule

// File: tb/tb_sfm_ctrl_fsm.sv
// Directed bench for the softmax job controller. Each step advances one clock
// and samples 1 ns after the rising edge; expected outputs are hand-derived
// from the state sequence of each job.
module tb_sfm_ctrl_fsm;
  import sfm_pkg::*;

  logic            clk_i;
  logic            rst_ni;
  logic            clear_i;
  logic            start_i;
  logic [31:0]     in_addr_i;
  logic [31:0]     out_addr_i;
  logic [31:0]     tot_len_i;
  logic [31:0]     commands_i;
  logic            strm_valid_o;
  logic            strm_ready_i;
  logic [31:0]     strm_rd_addr_o;
  logic [31:0]     strm_wr_addr_o;
  logic [31:0]     strm_len_o;
  logic            strm_write_o;
  logic            strm_done_i;
  datapath_flags_t dp_flags_i;
  datapath_ctrl_t  dp_ctrl_o;
  logic            busy_o;
  logic            done_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rd, exp_wr, exp_len;

  // dp nibble: {clear_regs, acc_finished, dividing, disable_max}
  localparam logic [3:0] DP_0   = 4'b0000;
  localparam logic [3:0] DP_CLR = 4'b1000;
  localparam logic [3:0] DP_FIN = 4'b0100;
  localparam logic [3:0] DP_DIV = 4'b0011;

  sfm_ctrl_fsm #(.ADDR_W(32), .LEN_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .in_addr_i      (in_addr_i),
    .out_addr_i     (out_addr_i),
    .tot_len_i      (tot_len_i),
    .commands_i     (commands_i),
    .strm_valid_o   (strm_valid_o),
    .strm_ready_i   (strm_ready_i),
    .strm_rd_addr_o (strm_rd_addr_o),
    .strm_wr_addr_o (strm_wr_addr_o),
    .strm_len_o     (strm_len_o),
    .strm_write_o   (strm_write_o),
    .strm_done_i    (strm_done_i),
    .dp_flags_i     (dp_flags_i),
    .dp_ctrl_o      (dp_ctrl_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic v, input logic w,
                          input logic [3:0] dp, input logic b, input logic d);
    logic [3:0] obs_dp;
    obs_dp = {dp_ctrl_o.clear_regs, dp_ctrl_o.accumulator_ctrl.acc_finished,
              dp_ctrl_o.dividing, dp_ctrl_o.disable_max};
    chk_w({tag, ".valid"}, {31'd0, strm_valid_o}, {31'd0, v});
    chk_w({tag, ".write"}, {31'd0, strm_write_o}, {31'd0, w});
    chk_w({tag, ".rd"},    strm_rd_addr_o, v ? exp_rd  : 32'h0);
    chk_w({tag, ".wr"},    strm_wr_addr_o, v ? exp_wr  : 32'h0);
    chk_w({tag, ".len"},   strm_len_o,     v ? exp_len : 32'h0);
    chk_w({tag, ".dp"},    {28'd0, obs_dp}, {28'd0, dp});
    chk_w({tag, ".busy"},  {31'd0, busy_o}, {31'd0, b});
    chk_w({tag, ".done"},  {31'd0, done_o}, {31'd0, d});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [31:0] ia, input logic [31:0] oa,
                      input logic [31:0] len, input logic [31:0] cmd);
    in_addr_i  = ia;
    out_addr_i = oa;
    tot_len_i  = len;
    commands_i = cmd;
    exp_rd  = ia;
    exp_wr  = oa;
    exp_len = len;
  endtask

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    strm_ready_i = 1'b1;
    strm_done_i  = 1'b0;
    dp_flags_i   = '0;
    load(32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    expect_o("reset", 0, 0, DP_0, 0, 0);
    rst_ni = 1'b1;
    step();
    expect_o("idle", 0, 0, DP_0, 0, 0);

    // Full job: cmd=0, len=16
    load(32'h0000_1000, 32'h0000_2000, 32'd16, 32'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_o("full.clear", 0, 0, DP_CLR, 1, 0);
    step(); expect_o("full.accreq", 1, 0, DP_0, 1, 0);
    step(); expect_o("full.accrun", 0, 0, DP_0, 1, 0);
    strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("full.accfin", 0, 0, DP_FIN, 1, 0);
    step(); expect_o("full.accwait", 0, 0, DP_0, 1, 0);
    step(); expect_o("full.divreq", 1, 1, DP_DIV, 1, 0);
    step(); expect_o("full.divrun", 0, 0, DP_DIV, 1, 0);
    strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("full.divwait", 0, 0, DP_DIV, 1, 0);
    step(); expect_o("full.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("full.idle", 0, 0, DP_0, 0, 0);

    // ACC_ONLY|PARTIAL: no clear, no acc_finished, no write pass
    load(32'h0000_3000, 32'h0000_4000, 32'd7, 32'd5);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_o("part.accreq", 1, 0, DP_0, 1, 0);
    step(); expect_o("part.accrun", 0, 0, DP_0, 1, 0);
    strm_done_i = 1'b1; dp_flags_i.reducing = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("part.accwait", 0, 0, DP_0, 1, 0);
    dp_flags_i.reducing = 1'b0; dp_flags_i.datapath_busy = 1'b1;
    step(); expect_o("part.accwait_busy", 0, 0, DP_0, 1, 0);
    dp_flags_i.datapath_busy = 1'b0;
    step(); expect_o("part.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("part.idle", 0, 0, DP_0, 0, 0);

    // DIV_ONLY: single write request
    load(32'h0000_5000, 32'h0000_6000, 32'd9, 32'd2);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_o("divo.divreq", 1, 1, DP_DIV, 1, 0);
    step(); expect_o("divo.divrun", 0, 0, DP_DIV, 1, 0);
    strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("divo.divwait", 0, 0, DP_DIV, 1, 0);
    step(); expect_o("divo.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("divo.idle", 0, 0, DP_0, 0, 0);

    // Both mode bits: ACC_ONLY flow (clear, read, acc_finished, no write)
    load(32'h0000_7000, 32'h0000_8000, 32'd3, 32'd3);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_o("both.clear", 0, 0, DP_CLR, 1, 0);
    step(); expect_o("both.accreq", 1, 0, DP_0, 1, 0);
    step(); strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("both.accfin", 0, 0, DP_FIN, 1, 0);
    step(); expect_o("both.accwait", 0, 0, DP_0, 1, 0);
    step(); expect_o("both.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("both.idle", 0, 0, DP_0, 0, 0);

    // Backpressure, maximum length, start mid-job ignored, early strm_done ignored
    load(32'hA000_0000, 32'hB000_0004, 32'hFFFF_FFFF, 32'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    strm_ready_i = 1'b0;
    expect_o("bp.clear", 0, 0, DP_CLR, 1, 0);
    step(); expect_o("bp.accreq", 1, 0, DP_0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start_i    = 1'b1;
        in_addr_i  = 32'hDEAD_BEEF;
        out_addr_i = 32'h1234_5678;
        tot_len_i  = 32'd1;
      end
      if (i == 2) begin
        start_i     = 1'b0;
        strm_done_i = 1'b1;
      end
      if (i == 3) strm_done_i = 1'b0;
      step();
      expect_o("bp.hold", 1, 0, DP_0, 1, 0);
    end
    strm_ready_i = 1'b1;
    step(); expect_o("bp.accrun", 0, 0, DP_0, 1, 0);
    strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("bp.accfin", 0, 0, DP_FIN, 1, 0);
    dp_flags_i.datapath_busy = 1'b1;
    step(); expect_o("bp.accwait", 0, 0, DP_0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_o("bp.busywait", 0, 0, DP_0, 1, 0);
    end
    dp_flags_i.datapath_busy = 1'b0;
    step(); expect_o("bp.divreq", 1, 1, DP_DIV, 1, 0);
    step(); strm_done_i = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("bp.divwait", 0, 0, DP_DIV, 1, 0);
    step(); expect_o("bp.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("bp.idle", 0, 0, DP_0, 0, 0);

    // Zero length: straight to DONE, no request
    load(32'h0000_1111, 32'h0000_2222, 32'd0, 32'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    expect_o("zero.done", 0, 0, DP_0, 1, 1);
    step(); expect_o("zero.idle", 0, 0, DP_0, 0, 0);

    // clear_i together with start_i: start dropped
    load(32'h0000_1111, 32'h0000_2222, 32'd4, 32'd0);
    start_i = 1'b1; clear_i = 1'b1;
    step(); start_i = 1'b0; clear_i = 1'b0;
    expect_o("clrstart", 0, 0, DP_0, 0, 0);

    // clear_i in DIV_RUN
    load(32'h0000_9000, 32'h0000_A000, 32'd5, 32'd2);
    start_i = 1'b1; step(); start_i = 1'b0;
    step(); expect_o("clr.divrun", 0, 0, DP_DIV, 1, 0);
    clear_i = 1'b1;
    step(); clear_i = 1'b0;
    expect_o("clr.idle", 0, 0, DP_0, 0, 0);
    step(); expect_o("clr.nodone", 0, 0, DP_0, 0, 0);

    // rst_ni low in ACC_WAIT
    load(32'h0000_C000, 32'h0000_D000, 32'd8, 32'd5);
    start_i = 1'b1; step(); start_i = 1'b0;
    step(); strm_done_i = 1'b1; dp_flags_i.datapath_busy = 1'b1;
    step(); strm_done_i = 1'b0;
    expect_o("rst.accwait", 0, 0, DP_0, 1, 0);
    rst_ni = 1'b0;
    #2;
    expect_o("rst.async", 0, 0, DP_0, 0, 0);
    rst_ni = 1'b1;
    dp_flags_i.datapath_busy = 1'b0;
    step(); expect_o("rst.idle", 0, 0, DP_0, 0, 0);
    step(); expect_o("rst.nodone", 0, 0, DP_0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
